commutator_output: RTL and testbench

COMMUTATOR_OUTPUT -- requirements
Module: commutator_output

---
 rtl/commutator_output_if.sv | 28 ++
 rtl/commutator_output.sv | 135 +++++++++++++
 tb/tb_commutator_output.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/commutator_output_if.sv
// Pair-in / serial-out bus of the commutator output stage.
// The DUT connects through the slave modport; the source/sink side uses master.
interface commutator_output_if;
  localparam int unsigned DW = 13;

  logic                 mode;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] Up_in_re;
  logic signed [DW-1:0] Up_in_im;
  logic signed [DW-1:0] Low_in_re;
  logic signed [DW-1:0] Low_in_im;
  logic signed [DW-1:0] out_re;
  logic signed [DW-1:0] out_im;
  logic                 out_valid;
  logic                 out_sof;
  logic                 out_eof;

  modport slave (
    input  mode, in_valid, Up_in_re, Up_in_im, Low_in_re, Low_in_im,
    output in_ready, out_re, out_im, out_valid, out_sof, out_eof
  );

  modport master (
    output mode, in_valid, Up_in_re, Up_in_im, Low_in_re, Low_in_im,
    input  in_ready, out_re, out_im, out_valid, out_sof, out_eof
  );
endinterface

// File: rtl/commutator_output.sv
// Serialises 16 upper/lower sample pairs into a 32-point frame, either
// block ordered (uppers then buffered lowers) or interleaved (upper, lower).
module commutator_output (
  input  logic               clk,
  input  logic               rst_n,
  commutator_output_if.slave bus
);
  localparam int unsigned DW    = 13;
  localparam int unsigned NPAIR = 16;
  localparam int unsigned CW    = 4;
  localparam logic [CW-1:0] LAST = CW'(NPAIR - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    DRAIN = 3'd2,
    ILV_A = 3'd3,
    ILV_B = 3'd4
  } state_t;

  state_t               state, state_nxt;
  logic [CW-1:0]        cnt, cnt_nxt;
  logic                 mode_q, mode_nxt;
  logic signed [DW-1:0] re_nxt, im_nxt;
  logic                 valid_nxt, sof_nxt, eof_nxt;
  logic                 buf_we;
  logic                 ready_c;
  logic                 accept;
  logic [2*DW-1:0]      lower_buf [NPAIR];
  logic [2*DW-1:0]      buf_rd;

  assign ready_c      = (state == IDLE) || (state == FILL) || (state == ILV_A);
  assign bus.in_ready = ready_c;
  assign accept       = bus.in_valid & ready_c;
  assign buf_rd       = lower_buf[cnt];

  // Next-state and next-output decode; outputs hold their value unless presenting.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    mode_nxt  = mode_q;
    re_nxt    = bus.out_re;
    im_nxt    = bus.out_im;
    valid_nxt = 1'b0;
    sof_nxt   = 1'b0;
    eof_nxt   = 1'b0;
    buf_we    = 1'b0;

    case (state)
      IDLE: begin
        if (accept) begin
          mode_nxt  = bus.mode;
          re_nxt    = bus.Up_in_re;
          im_nxt    = bus.Up_in_im;
          valid_nxt = 1'b1;
          sof_nxt   = 1'b1;
          buf_we    = 1'b1;
          if (bus.mode) begin
            state_nxt = ILV_B;
          end else begin
            state_nxt = FILL;
            cnt_nxt   = CW'(1);
          end
        end
      end

      FILL, ILV_A: begin
        if (accept) begin
          re_nxt    = bus.Up_in_re;
          im_nxt    = bus.Up_in_im;
          valid_nxt = 1'b1;
          buf_we    = 1'b1;
          if (mode_q) begin
            state_nxt = ILV_B;
          end else if (cnt == LAST) begin
            state_nxt = DRAIN;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
      end

      DRAIN, ILV_B: begin
        re_nxt    = buf_rd[2*DW-1:DW];
        im_nxt    = buf_rd[DW-1:0];
        valid_nxt = 1'b1;
        if (cnt == LAST) begin
          eof_nxt   = 1'b1;
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
          if (state == ILV_B) begin
            state_nxt = ILV_A;
          end
        end
      end

      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      mode_q        <= 1'b0;
      bus.out_re    <= '0;
      bus.out_im    <= '0;
      bus.out_valid <= 1'b0;
      bus.out_sof   <= 1'b0;
      bus.out_eof   <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      mode_q        <= mode_nxt;
      bus.out_re    <= re_nxt;
      bus.out_im    <= im_nxt;
      bus.out_valid <= valid_nxt;
      bus.out_sof   <= sof_nxt;
      bus.out_eof   <= eof_nxt;
    end
  end

  // Lower-lane store; every entry is rewritten before it is read in a frame.
  always_ff @(posedge clk) begin
    if (buf_we) begin
      lower_buf[cnt] <= {bus.Low_in_re, bus.Low_in_im};
    end
  end
endmodule

// File: tb/tb_commutator_output.sv
// Self-checking bench for commutator_output: directed frames, a position
// table and randomized frames compared against a frame-level ordering model.
module tb_commutator_output;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  commutator_output_if bus ();

  commutator_output dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic signed [12:0] re;
    logic signed [12:0] im;
    logic               sof;
    logic               eof;
    int                 cyc;
  } obs_t;

  typedef struct {
    bit                 m;
    int                 pos;
    logic signed [12:0] re;
    logic signed [12:0] im;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rdy_low = 0;

  obs_t               obs[$];
  logic [27:0]        exp_q[$];
  int                 obs_base;
  int                 rl0;
  logic signed [12:0] f_up_re[16], f_up_im[16], f_lo_re[16], f_lo_im[16];
  int                 f_gap[16];
  vec_t               tbl[8];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.out_valid)
      obs.push_back('{bus.out_re, bus.out_im, bus.out_sof, bus.out_eof, cyc});
    if (!bus.in_ready) rdy_low <= rdy_low + 1;
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, expv);
    end
  endtask

  function automatic int obs_cyc(input int i);
    if (obs_base + i < obs.size()) return obs[obs_base + i].cyc;
    return -1000;
  endfunction

  task automatic std_frame();
    for (int k = 0; k < 16; k++) begin
      f_up_re[k] = 13'(k);
      f_up_im[k] = 13'(-k);
      f_lo_re[k] = 13'(k + 16);
      f_lo_im[k] = 13'(-(k + 16));
      f_gap[k]   = 0;
    end
  endtask

  task automatic rand_frame();
    for (int k = 0; k < 16; k++) begin
      f_up_re[k] = 13'($urandom);
      f_up_im[k] = 13'($urandom);
      f_lo_re[k] = 13'($urandom);
      f_lo_im[k] = 13'($urandom);
      f_gap[k]   = ($urandom_range(99) < 25) ? int'($urandom_range(3, 1)) : 0;
    end
  endtask

  // Frame-level reference: output point i of a frame, by ordering rule.
  task automatic build_expected(input logic m);
    logic signed [12:0] r, i_;
    for (int i = 0; i < 32; i++) begin
      if (!m) begin
        r  = (i < 16) ? f_up_re[i] : f_lo_re[i - 16];
        i_ = (i < 16) ? f_up_im[i] : f_lo_im[i - 16];
      end else begin
        r  = (i % 2 == 0) ? f_up_re[i / 2] : f_lo_re[i / 2];
        i_ = (i % 2 == 0) ? f_up_im[i / 2] : f_lo_im[i / 2];
      end
      exp_q.push_back({r, i_, (i == 0), (i == 31)});
    end
  endtask

  task automatic drive_pairs(input logic m, input int first, input int last,
                             input int toggle_at, input bit keep);
    bit rdy;
    int waited;
    for (int k = first; k <= last; k++) begin
      for (int g = 0; g < f_gap[k]; g++) begin
        bus.in_valid = 1'b0;
        @(negedge clk);
      end
      bus.mode      = (toggle_at >= 0 && k >= toggle_at) ? ~m : m;
      bus.in_valid  = 1'b1;
      bus.Up_in_re  = f_up_re[k];
      bus.Up_in_im  = f_up_im[k];
      bus.Low_in_re = f_lo_re[k];
      bus.Low_in_im = f_lo_im[k];
      waited = 0;
      while (1) begin
        rdy = bus.in_ready;
        @(negedge clk);
        if (rdy) break;
        waited++;
        if (waited > 64) begin
          chk("handshake_timeout", 64'd0, 64'd1);
          bus.in_valid = 1'b0;
          return;
        end
      end
    end
    if (!keep) bus.in_valid = 1'b0;
  endtask

  task automatic start_test();
    obs_base = obs.size();
    exp_q.delete();
    rl0 = rdy_low;
  endtask

  task automatic settle();
    repeat (40) @(negedge clk);
  endtask

  task automatic compare_stream(input string name);
    obs_t o;
    chk({name, "_count"}, 64'(obs.size() - obs_base), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (obs_base + i < obs.size()) begin
        o = obs[obs_base + i];
        chk($sformatf("%s_pt%0d", name, i), {36'd0, o.re, o.im, o.sof, o.eof}, {36'd0, exp_q[i]});
      end
    end
  endtask

  task automatic check_table(input bit m);
    obs_t o;
    for (int t = 0; t < 8; t++) begin
      if (tbl[t].m == m && obs_base + tbl[t].pos < obs.size()) begin
        o = obs[obs_base + tbl[t].pos];
        chk($sformatf("tbl_m%0d_p%0d", m, tbl[t].pos), {38'd0, o.re, o.im},
            {38'd0, tbl[t].re, tbl[t].im});
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int rel;
    logic m;

    tbl[0] = '{1'b0, 0,  13'sd0,  13'sd0};
    tbl[1] = '{1'b0, 15, 13'sd15, -13'sd15};
    tbl[2] = '{1'b0, 16, 13'sd16, -13'sd16};
    tbl[3] = '{1'b0, 31, 13'sd31, -13'sd31};
    tbl[4] = '{1'b1, 1,  13'sd16, -13'sd16};
    tbl[5] = '{1'b1, 2,  13'sd1,  -13'sd1};
    tbl[6] = '{1'b1, 30, 13'sd15, -13'sd15};
    tbl[7] = '{1'b1, 31, 13'sd31, -13'sd31};

    // Reset with a pair already offered, then first acceptance right after release
    std_frame();
    bus.mode      = 1'b0;
    bus.in_valid  = 1'b1;
    bus.Up_in_re  = f_up_re[0];
    bus.Up_in_im  = f_up_im[0];
    bus.Low_in_re = f_lo_re[0];
    bus.Low_in_im = f_lo_im[0];
    repeat (3) @(negedge clk);
    chk("reset_outputs",
        {34'd0, bus.out_re, bus.out_im, bus.out_valid, bus.out_sof, bus.out_eof, bus.in_ready},
        {34'd0, 26'd0, 3'd0, 1'b1});
    start_test();
    build_expected(1'b0);
    rst_n = 1'b1;
    rel = cyc;
    drive_pairs(1'b0, 0, 15, -1, 1'b0);
    settle();
    compare_stream("mode0");
    chk("first_accept_latency", 64'(obs_cyc(0)), 64'(rel + 1));
    chk("mode0_span", 64'(obs_cyc(31) - obs_cyc(0)), 64'd31);
    chk("mode0_ready_low", 64'(rdy_low - rl0), 64'd16);
    check_table(1'b0);

    // Interleaved ordering
    std_frame();
    start_test();
    build_expected(1'b1);
    drive_pairs(1'b1, 0, 15, -1, 1'b0);
    settle();
    compare_stream("mode1");
    chk("mode1_span", 64'(obs_cyc(31) - obs_cyc(0)), 64'd31);
    chk("mode1_ready_low", 64'(rdy_low - rl0), 64'd16);
    check_table(1'b1);

    // Three-cycle bubble after pair 5
    std_frame();
    f_gap[6] = 3;
    start_test();
    build_expected(1'b0);
    drive_pairs(1'b0, 0, 15, -1, 1'b0);
    settle();
    compare_stream("bubble");
    chk("bubble_span", 64'(obs_cyc(31) - obs_cyc(0)), 64'd34);
    chk("bubble_gap", 64'(obs_cyc(6) - obs_cyc(5)), 64'd4);

    // Mode toggled mid-frame is ignored
    std_frame();
    start_test();
    build_expected(1'b0);
    drive_pairs(1'b0, 0, 15, 8, 1'b0);
    settle();
    compare_stream("toggle0");
    start_test();
    build_expected(1'b1);
    drive_pairs(1'b1, 0, 15, 8, 1'b0);
    settle();
    compare_stream("toggle1");

    // Reset at pair 8 aborts; next frame starts clean
    std_frame();
    start_test();
    drive_pairs(1'b0, 0, 7, -1, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midframe_reset_outputs",
        {34'd0, bus.out_re, bus.out_im, bus.out_valid, bus.out_sof, bus.out_eof, bus.in_ready},
        {34'd0, 26'd0, 3'd0, 1'b1});
    repeat (2) @(negedge clk);
    std_frame();
    f_up_re[0] = 13'sd5;
    f_up_im[0] = -13'sd3;
    start_test();
    build_expected(1'b0);
    rst_n = 1'b1;
    drive_pairs(1'b0, 0, 15, -1, 1'b0);
    settle();
    compare_stream("post_reset");
    if (obs_base < obs.size())
      chk("post_reset_first", {37'd0, obs[obs_base].re, obs[obs_base].im, obs[obs_base].sof},
          {37'd0, 13'h0005, 13'h1FFD, 1'b1});
    else
      chk("post_reset_first_present", 64'd0, 64'd1);

    // Back-to-back block frames
    std_frame();
    start_test();
    build_expected(1'b0);
    build_expected(1'b0);
    drive_pairs(1'b0, 0, 15, -1, 1'b1);
    drive_pairs(1'b0, 0, 15, -1, 1'b0);
    settle();
    compare_stream("b2b");
    chk("b2b_sof_follows_eof", 64'(obs_cyc(32) - obs_cyc(31)), 64'd1);
    chk("b2b_span", 64'(obs_cyc(63) - obs_cyc(0)), 64'd63);
    chk("b2b_ready_low", 64'(rdy_low - rl0), 64'd32);

    // Randomized data, modes, bubbles and frame chaining
    start_test();
    for (int f = 0; f < 10; f++) begin
      m = 1'($urandom_range(1));
      rand_frame();
      build_expected(m);
      drive_pairs(m, 0, 15, -1, (f < 9));
    end
    settle();
    compare_stream("random");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
